// File: rtl/soc_cpu_mul_pkg.sv
// Shared types and defaults for the CPU two-pass multiply sequencer.
//   mul_state_t : sequencer state encoding (IDLE, PASS1, PASS2, RESP)
//   MUL_LAT_DEF : default multiply-cell latency in cycles
//   MUL_TAG_W   : default destination-tag width
package soc_cpu_mul_pkg;

  localparam int unsigned MUL_LAT_DEF = 1;
  localparam int unsigned MUL_TAG_W   = 5;
  localparam int unsigned MUL_DATA_W  = 32;
  // Wide enough to hold any supported MUL_LAT (1..3)
  localparam int unsigned MUL_CNT_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } mul_state_t;

endpackage : soc_cpu_mul_pkg

// File: rtl/soc_cpu_mul_seq.sv
// Two-pass sequencer for the CPU 32x32->32 multiply. Drives the external
// 32x16 multiply cell once with B[15:0] and once with B[31:16] (the second
// pass is skipped when B[31:16] is zero), then returns the low 32 bits of A*B.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   req_valid/req_ready          : request handshake
//   req_src1, req_src2, req_tag  : operands A, B and destination tag
//   flush                        : kill the in-flight operation
//   M_mul_src1, M_mul_src2       : operands driven to the multiply cell
//   M_mul_cell_result            : partial product from the cell
//   rsp_valid/rsp_ready          : response handshake
//   rsp_result, rsp_tag          : low 32 bits of A*B and its tag
//   busy                         : sequencer not idle
module soc_cpu_mul_seq
  import soc_cpu_mul_pkg::*;
#(
  parameter int unsigned DATA_W  = MUL_DATA_W,
  parameter int unsigned TAG_W   = MUL_TAG_W,
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_src1,
  input  logic [DATA_W-1:0] req_src2,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic              flush,
  output logic [DATA_W-1:0] M_mul_src1,
  output logic [DATA_W-1:0] M_mul_src2,
  input  logic [DATA_W-1:0] M_mul_cell_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned CNT_W  = MUL_CNT_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT);

  mul_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [HALF_W-1:0]   b_hi_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   src1_q;
  logic [DATA_W-1:0]   src2_q;
  logic [DATA_W-1:0]   result_q;
  logic [TAG_W-1:0]    tag_q;
  logic                rsp_valid_q;
  logic                busy_q;

  logic                accept_c;
  logic                capture_c;

  // Accept in IDLE, or in RESP when the current result leaves this cycle
  assign req_ready = reset_n && !flush &&
                     ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));
  assign accept_c  = req_valid && req_ready;
  // Cell output is valid once the latency countdown has expired
  assign capture_c = (cnt_q == '0);

  // Sequencer state, operand and result registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      b_hi_q      <= '0;
      acc_q       <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      result_q    <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (accept_c) begin
      // Covers both IDLE accept and back-to-back accept during RESP handshake
      src1_q      <= req_src1;
      src2_q      <= req_src2;
      b_hi_q      <= req_src2[DATA_W-1:HALF_W];
      tag_q       <= req_tag;
      cnt_q       <= CNT_LOAD;
      state_q     <= ST_PASS1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        ST_PASS1: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!capture_c) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            acc_q <= M_mul_cell_result;
            if (b_hi_q == '0) begin
              // High half of B is zero: first partial product is the answer
              result_q    <= M_mul_cell_result;
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              src2_q  <= {{HALF_W{1'b0}}, b_hi_q};
              cnt_q   <= CNT_LOAD;
              state_q <= ST_PASS2;
            end
          end
        end
        ST_PASS2: begin
          if (flush) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (!capture_c) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            // A*B mod 2^32 = A*B_lo + (A*B_hi << 16), both terms mod 2^32
            result_q    <= acc_q + (M_mul_cell_result << HALF_W);
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_RESP: begin
          // A flush also ends RESP; result is dropped if not yet taken
          if (flush || rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign M_mul_src1 = src1_q;
  assign M_mul_src2 = src2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;
  assign busy       = busy_q;

endmodule : soc_cpu_mul_seq

// File: tb/tb_soc_cpu_mul_seq.sv
// Bench for soc_cpu_mul_seq: directed requests against a transaction-level
// model of the sequencer plus an attached multiply-cell model.
module tb_soc_cpu_mul_seq;

  localparam int L  = 1;
  localparam int TW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_src1;
  logic [31:0]   req_src2;
  logic [TW-1:0] req_tag;
  logic          flush;
  logic [31:0]   M_mul_src1;
  logic [31:0]   M_mul_src2;
  logic [31:0]   M_mul_cell_result;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          busy;

  always #5 clk = ~clk;

  soc_cpu_mul_seq #(.DATA_W(32), .TAG_W(TW), .MUL_LAT(L)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_src1          (req_src1),
    .req_src2          (req_src2),
    .req_tag           (req_tag),
    .flush             (flush),
    .M_mul_src1        (M_mul_src1),
    .M_mul_src2        (M_mul_src2),
    .M_mul_cell_result (M_mul_cell_result),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_result        (rsp_result),
    .rsp_tag           (rsp_tag),
    .busy              (busy)
  );

  // Multiply cell: (src1 * src2[15:0]) mod 2^32, L register stages
  logic [31:0] cell_pipe [L];
  always @(posedge clk) begin
    cell_pipe[0] <= M_mul_src1 * {16'h0, M_mul_src2[15:0]};
    for (int i = 1; i < L; i++) cell_pipe[i] <= cell_pipe[i-1];
  end
  assign M_mul_cell_result = cell_pipe[L-1];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding op, response due at a fixed cycle
  int          cyc = 0;
  bit          chk_en = 1'b0;
  bit          m_live = 1'b0;
  int          m_vcyc = 0;
  logic [31:0] m_res, m_src1, m_src2, m_hi;
  logic [TW-1:0] m_tag;
  bit          m_hi_pend = 1'b0;
  int          m_sw_cyc = 0;

  always @(posedge clk) begin
    bit resp_now;
    bit rdy;
    if (!reset_n) begin
      m_live    = 1'b0;
      m_hi_pend = 1'b0;
      m_src1    = '0;
      m_src2    = '0;
      m_res     = '0;
      m_tag     = '0;
      chk_en    = 1'b1;
    end else begin
      resp_now = m_live && (cyc >= m_vcyc);
      rdy      = !flush && (!m_live || (resp_now && rsp_ready));
      if (flush) begin
        m_live    = 1'b0;
        m_hi_pend = 1'b0;
      end else begin
        if (m_hi_pend && cyc == m_sw_cyc) begin
          m_src2    = m_hi;
          m_hi_pend = 1'b0;
        end
        if (resp_now && rsp_ready) m_live = 1'b0;
      end
      if (rdy && req_valid) begin
        longint unsigned prod;
        prod      = longint'(req_src1) * longint'(req_src2);
        m_live    = 1'b1;
        m_src1    = req_src1;
        m_src2    = req_src2;
        m_tag     = req_tag;
        m_res     = prod[31:0];
        m_hi      = {16'h0, req_src2[31:16]};
        m_hi_pend = (req_src2[31:16] != 16'h0);
        m_sw_cyc  = cyc + L + 1;
        m_vcyc    = cyc + (m_hi_pend ? 2*L+3 : L+2);
      end
    end
    cyc++;
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    logic ev;
    if (chk_en) begin
      ev = m_live && (cyc >= m_vcyc);
      chk("req_ready", req_ready, reset_n ? (!flush && (!m_live || (ev && rsp_ready))) : 1'b0);
      chk("rsp_valid", rsp_valid, ev);
      chk("busy", busy, m_live);
      chk("mul_src1", M_mul_src1, m_src1);
      chk("mul_src2", M_mul_src2, m_src2);
      if (ev) begin
        chk("rsp_result", rsp_result, m_res);
        chk("rsp_tag", rsp_tag, m_tag);
      end
    end
  end

  // Handshake monitor for the back-to-back run
  bit       burst_on = 1'b0;
  int       hs_cnt = 0;
  int       burst_seen = 0;
  longint   last_hs_t = 0;
  always @(posedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) begin
      hs_cnt++;
      if (burst_on) begin
        chk("b2b_tag", rsp_tag, TW'(burst_seen));
        if (burst_seen > 0) chk("b2b_gap", longint'($time) - last_hs_t, 50);
        burst_seen++;
      end
      last_hs_t = longint'($time);
    end
  end

  // Issue one request from IDLE; called #1 after a rising edge
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] tag,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int k;
    logic [31:0] hi;
    hi        = {16'h0, b[31:16]};
    req_src1  = a;
    req_src2  = b;
    req_tag   = tag;
    req_valid = 1'b1;
    rsp_ready = (hold == 0);
    #1 chk("accept_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 20) begin
      if (hi != 0 && k == L+2) chk("pass2_src2", M_mul_src2, hi);
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, exp_lat);
    chk("result", rsp_result, exp_res);
    chk("tag", rsp_tag, tag);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_result", rsp_result, exp_res);
      chk("hold_req_ready", req_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got time %0t required below 100000", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    int base;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_src1  = '0;
    req_src2  = '0;
    req_tag   = '0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_result", rsp_result, 32'h0);
    chk("rst_src1", M_mul_src1, 32'h0);
    reset_n = 1'b1;
    #1 chk("post_rst_req_ready", req_ready, 1'b1);

    // Skip path and full two-pass path
    run_op(32'd3, 32'd5, 5'd7, 32'd15, 3, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 5, 0);
    // Back-pressure: result must hold for 6 cycles
    run_op(32'h0001_0003, 32'h0002_0002, 5'd2, 32'h0008_0006, 5, 6);

    // Back-to-back: ten requests, one accepted per RESP handshake
    base       = hs_cnt;
    burst_on   = 1'b1;
    burst_seen = 0;
    for (int i = 0; i < 10; i++) begin
      req_src1  = 32'h1234_5678 + 32'(i) * 32'h0101_0101;
      req_src2  = 32'h0003_0001 + 32'(i * 7);
      req_tag   = TW'(i);
      req_valid = 1'b1;
      if (i == 0) @(posedge clk);
      else repeat (5) @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    burst_on = 1'b0;
    chk("b2b_count", hs_cnt - base, 10);

    // Flush in cycle 2 of an operation: no response
    req_src1  = 32'd7;
    req_src2  = 32'h0001_0000;
    req_tag   = 5'd4;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 1'b0);
    v = 0;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid) v++;
      @(posedge clk); #1;
    end
    chk("flush_no_rsp", v, 0);
    run_op(32'd2, 32'd2, 5'd3, 32'd4, 3, 0);

    // Reset while in PASS2
    req_src1  = 32'd5;
    req_src2  = 32'h0003_0004;
    req_tag   = 5'd9;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_src2", M_mul_src2, 32'h0000_0003);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_result", rsp_result, 32'h0);
    chk("mid_rst_tag", rsp_tag, 5'd0);
    chk("mid_rst_src1", M_mul_src1, 32'h0);
    chk("mid_rst_src2", M_mul_src2, 32'h0);
    reset_n   = 1'b1;
    req_valid = 1'b1;
    flush     = 1'b1;
    #1 chk("flush_req_ready", req_ready, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    flush     = 1'b0;
    chk("flushed_req_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Wrap-around boundaries: products of exactly 2^32
    run_op(32'h8000_0000, 32'h0000_0002, 5'd10, 32'h0, 3, 0);
    run_op(32'h0001_0000, 32'h0001_0000, 5'd11, 32'h0, 5, 0);
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_soc_cpu_mul_seq
